// File: rtl/secded_updown_counter_if.sv
// Bus for secded_updown_counter: control/load/fault-injection inputs and the
// corrected count, error flags and error statistics outputs.
//   master : drives enable, updown, load, load_value, inject_en, inject_mask
//   slave  : drives count, single_err, double_err, err_syndrome, fault, wrap,
//            corr_count, uncorr_count
interface secded_updown_counter_if #(
    parameter int DATA_W   = 3,
    parameter int ERRCNT_W = 8
);
    // Smallest P with 2^P >= DATA_W+P+1
    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        for (int k = 0; k < 16; k++)
            if ((1 << p) < dw + p + 1) p = p + 1;
        return p;
    endfunction

    localparam int P  = calc_p(DATA_W);
    localparam int CW = DATA_W + P + 1;

    logic                enable;
    logic                updown;
    logic                load;
    logic [DATA_W-1:0]   load_value;
    logic                inject_en;
    logic [CW-1:0]       inject_mask;
    logic [DATA_W-1:0]   count;
    logic                single_err;
    logic                double_err;
    logic [P-1:0]        err_syndrome;
    logic                fault;
    logic                wrap;
    logic [ERRCNT_W-1:0] corr_count;
    logic [ERRCNT_W-1:0] uncorr_count;

    modport master (
        output enable, updown, load, load_value, inject_en, inject_mask,
        input  count, single_err, double_err, err_syndrome, fault, wrap,
               corr_count, uncorr_count
    );

    modport slave (
        input  enable, updown, load, load_value, inject_en, inject_mask,
        output count, single_err, double_err, err_syndrome, fault, wrap,
               corr_count, uncorr_count
    );
endinterface

// File: rtl/secded_updown_counter.sv
// Fault-tolerant modulo-2^DATA_W up/down counter. State is kept as an
// extended-Hamming (SECDED) codeword that is decoded, corrected and
// re-encoded every cycle, so single upsets are scrubbed; a double error
// freezes the counter until a load.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset, clears all state
//   bus   : secded_updown_counter_if slave (controls in, count/flags/stats out)
module secded_updown_counter #(
    parameter int DATA_W   = 3,
    parameter int ERRCNT_W = 8
) (
    input  logic clock,
    input  logic reset,
    secded_updown_counter_if.slave bus
);
    function automatic int calc_p(input int dw);
        int p;
        p = 1;
        for (int k = 0; k < 16; k++)
            if ((1 << p) < dw + p + 1) p = p + 1;
        return p;
    endfunction

    localparam int P  = calc_p(DATA_W);
    localparam int CW = DATA_W + P + 1;

    // Data fills the non-power-of-two positions 1..CW-1, LSB first
    function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CW-1:0] w;
        int di;
        w  = '0;
        di = 0;
        for (int i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                w[i] = d[di];
                di   = di + 1;
            end
        end
        for (int k = 0; k < P; k++)
            for (int i = 1; i < CW; i++)
                if ((((i >> k) & 1) == 1) && (i != (1 << k)))
                    w[1 << k] = w[1 << k] ^ w[i];
        w[0] = ^w[CW-1:1];
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] w);
        logic [DATA_W-1:0] d;
        int di;
        d  = '0;
        di = 0;
        for (int i = 1; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[di] = w[i];
                di    = di + 1;
            end
        end
        return d;
    endfunction

    logic [CW-1:0]       r_word;
    logic                r_fault;
    logic                r_wrap;
    logic [ERRCNT_W-1:0] r_corr;
    logic [ERRCNT_W-1:0] r_uncorr;

    logic [P-1:0]        w_syn;
    logic                w_op;
    logic                w_single;
    logic                w_double;
    logic [CW-1:0]       w_fixed;
    logic [DATA_W-1:0]   w_count;
    logic [CW-1:0]       w_mask;

    always_comb begin
        w_syn = '0;
        for (int i = 1; i < CW; i++)
            if (r_word[i]) w_syn = w_syn ^ P'(i);
        w_op     = ^r_word;
        w_single = w_op && (int'(w_syn) <= CW - 1);
        w_double = (!w_op && (w_syn != '0)) || (w_op && (int'(w_syn) > CW - 1));
        // syn==0 with odd parity points at the overall parity bit itself
        w_fixed  = r_word;
        for (int i = 0; i < CW; i++)
            if (w_single && (int'(w_syn) == i)) w_fixed[i] = ~r_word[i];
        // On a double error w_fixed equals r_word, so count is the raw data
        w_count  = extract(w_fixed);
        w_mask   = bus.inject_en ? bus.inject_mask : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_word   <= '0;
            r_fault  <= 1'b0;
            r_wrap   <= 1'b0;
            r_corr   <= '0;
            r_uncorr <= '0;
        end else begin
            if (w_single && !(&r_corr))   r_corr   <= r_corr + ERRCNT_W'(1);
            if (w_double && !(&r_uncorr)) r_uncorr <= r_uncorr + ERRCNT_W'(1);

            if (bus.load) begin
                r_word  <= encode(bus.load_value) ^ w_mask;
                r_fault <= 1'b0;
                r_wrap  <= 1'b0;
            end else if (r_fault || w_double) begin
                // Frozen: no scrub, no injection
                r_fault <= 1'b1;
                r_wrap  <= 1'b0;
            end else if (bus.enable) begin
                if (bus.updown) begin
                    r_word <= encode(w_count + DATA_W'(1)) ^ w_mask;
                    r_wrap <= &w_count;
                end else begin
                    r_word <= encode(w_count - DATA_W'(1)) ^ w_mask;
                    r_wrap <= (w_count == '0);
                end
            end else begin
                r_word <= encode(w_count) ^ w_mask;
                r_wrap <= 1'b0;
            end
        end
    end

    assign bus.count        = w_count;
    assign bus.single_err   = w_single;
    assign bus.double_err   = w_double;
    assign bus.err_syndrome = w_syn;
    assign bus.fault        = r_fault;
    assign bus.wrap         = r_wrap;
    assign bus.corr_count   = r_corr;
    assign bus.uncorr_count = r_uncorr;
endmodule

// File: tb/tb_secded_updown_counter.sv
// Directed test of secded_updown_counter (DATA_W=3): counting and wrap,
// single-error correction and scrub, parity-bit error, double-error freeze,
// load recovery, asynchronous reset and statistics saturation.
module tb_secded_updown_counter;
    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    secded_updown_counter_if #(.DATA_W(3), .ERRCNT_W(8)) bus ();

    secded_updown_counter #(.DATA_W(3), .ERRCNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; sample 1 ns after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.enable      = 1'b0;
        bus.updown      = 1'b1;
        bus.load        = 1'b0;
        bus.load_value  = '0;
        bus.inject_en   = 1'b0;
        bus.inject_mask = '0;
    endtask

    task automatic do_load(input logic [2:0] v);
        idle();
        bus.load       = 1'b1;
        bus.load_value = v;
        tick();
        bus.load = 1'b0;
    endtask

    initial begin
        logic [2:0] up_cnt [9];
        logic       up_wrp [9];
        n_cmp = 0;
        n_err = 0;
        up_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        up_wrp = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
        idle();
        reset = 1'b1;
        #12;
        check("rst_count", int'(bus.count), 0);
        check("rst_fault", int'(bus.fault), 0);
        check("rst_wrap", int'(bus.wrap), 0);
        check("rst_single", int'(bus.single_err), 0);
        check("rst_double", int'(bus.double_err), 0);
        check("rst_corr", int'(bus.corr_count), 0);
        reset = 1'b0;
        #1;

        // 1. count up 9 cycles, then down through 0
        bus.enable = 1'b1;
        bus.updown = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("up_count%0d", i), int'(bus.count), int'(up_cnt[i]));
            check($sformatf("up_wrap%0d", i), int'(bus.wrap), int'(up_wrp[i]));
        end
        bus.updown = 1'b0;
        tick();
        check("dn_count0", int'(bus.count), 0);
        check("dn_wrap0", int'(bus.wrap), 0);
        tick();
        check("dn_count7", int'(bus.count), 7);
        check("dn_wrap7", int'(bus.wrap), 1);
        tick();
        check("dn_count6", int'(bus.count), 6);
        check("dn_wrap6", int'(bus.wrap), 0);

        // 2. single error on a data position (pos 3) at count 5
        do_load(3'd5);
        check("ld5_count", int'(bus.count), 5);
        bus.inject_en   = 1'b1;
        bus.inject_mask = 7'b0001000;
        tick();
        bus.inject_en = 1'b0;
        check("se_count", int'(bus.count), 5);
        check("se_single", int'(bus.single_err), 1);
        check("se_syn", int'(bus.err_syndrome), 3);
        check("se_double", int'(bus.double_err), 0);
        tick();
        check("se_scrub", int'(bus.single_err), 0);
        check("se_corr", int'(bus.corr_count), 1);
        check("se_count2", int'(bus.count), 5);

        // 3. error on the overall parity bit at count 2
        do_load(3'd2);
        bus.inject_en   = 1'b1;
        bus.inject_mask = 7'b0000001;
        tick();
        bus.inject_en = 1'b0;
        check("p0_single", int'(bus.single_err), 1);
        check("p0_syn", int'(bus.err_syndrome), 0);
        check("p0_count", int'(bus.count), 2);
        tick();
        check("p0_scrub", int'(bus.single_err), 0);
        check("p0_corr", int'(bus.corr_count), 2);

        // 4. double error while counting 4->5 (parity bits 1,2 flipped)
        do_load(3'd4);
        bus.enable      = 1'b1;
        bus.updown      = 1'b1;
        bus.inject_en   = 1'b1;
        bus.inject_mask = 7'b0000110;
        tick();
        bus.inject_en = 1'b0;
        check("de_double", int'(bus.double_err), 1);
        check("de_count", int'(bus.count), 5);
        check("de_fault0", int'(bus.fault), 0);
        check("de_uncorr0", int'(bus.uncorr_count), 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("fz_fault%0d", i), int'(bus.fault), 1);
            check($sformatf("fz_count%0d", i), int'(bus.count), 5);
            check($sformatf("fz_uncorr%0d", i), int'(bus.uncorr_count), i);
        end

        // 5. load clears the fault and counting resumes
        bus.load       = 1'b1;
        bus.load_value = 3'd6;
        tick();
        bus.load = 1'b0;
        check("rl_fault", int'(bus.fault), 0);
        check("rl_count", int'(bus.count), 6);
        check("rl_double", int'(bus.double_err), 0);
        check("rl_uncorr", int'(bus.uncorr_count), 6);
        tick();
        check("rs_count7", int'(bus.count), 7);
        tick();
        check("rs_count0", int'(bus.count), 0);
        check("rs_wrap", int'(bus.wrap), 1);

        // 6. asynchronous reset between edges with an error pending
        do_load(3'd3);
        bus.inject_en   = 1'b1;
        bus.inject_mask = 7'b0000001;
        tick();
        bus.inject_en = 1'b0;
        check("ar_pre_single", int'(bus.single_err), 1);
        check("ar_pre_count", int'(bus.count), 3);
        #2;
        reset = 1'b1;
        #1;
        check("ar_count", int'(bus.count), 0);
        check("ar_single", int'(bus.single_err), 0);
        check("ar_syn", int'(bus.err_syndrome), 0);
        check("ar_fault", int'(bus.fault), 0);
        check("ar_corr", int'(bus.corr_count), 0);
        check("ar_uncorr", int'(bus.uncorr_count), 0);
        #2;
        reset = 1'b0;

        // Saturation: re-inject a single error on every edge for 300 edges
        idle();
        bus.inject_en   = 1'b1;
        bus.inject_mask = 7'b0000001;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 255) check("sat_corr254", int'(bus.corr_count), 254);
            if (k == 256) check("sat_corr255", int'(bus.corr_count), 255);
        end
        check("sat_corr_hold", int'(bus.corr_count), 255);
        check("sat_single", int'(bus.single_err), 1);
        check("sat_uncorr", int'(bus.uncorr_count), 0);
        check("sat_count", int'(bus.count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
